// File: rtl/nvlink_tx_pkg.sv
// Shared types and default sizing for the NVLink TX virtual-channel scheduler.
package nvlink_tx_pkg;

    typedef enum logic [1:0] {
        DOWN = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } sched_state_e;

    localparam int NUM_VC_DEF       = 4;
    localparam int PAYLOAD_W_DEF    = 96;
    localparam int COH_W_DEF        = 8;
    localparam int MAX_CREDITS_DEF  = 8;
    localparam int IDLE_TIMEOUT_DEF = 64;

    localparam int VC_IDX_W = $clog2(NUM_VC_DEF);

    typedef logic [VC_IDX_W-1:0] vc_idx_t;

endpackage

// File: rtl/nvlink_tx_vc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after ptr wins.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any_grant
);

    logic [W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = W'((int'(ptr) + k) % N);
            if (!any_grant && eligible[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/nvlink_tx_vc_scheduler.sv
// Credit-gated round-robin scheduler feeding the shared NVLink TX framing datapath.
module nvlink_tx_vc_scheduler
    import nvlink_tx_pkg::*;
#(
    parameter int NUM_VC       = NUM_VC_DEF,
    parameter int PAYLOAD_W    = PAYLOAD_W_DEF,
    parameter int COH_W        = COH_W_DEF,
    parameter int MAX_CREDITS  = MAX_CREDITS_DEF,
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          link_up,
    input  logic [NUM_VC-1:0]             req_valid,
    output logic [NUM_VC-1:0]             req_ready,
    input  logic [NUM_VC*PAYLOAD_W-1:0]   req_payload,
    input  logic [NUM_VC*COH_W-1:0]       req_coh,
    input  logic                          credit_ret_valid,
    input  logic [$clog2(NUM_VC)-1:0]     credit_ret_vc,
    output logic [PAYLOAD_W-1:0]          tx_payload,
    output logic [COH_W-1:0]              tx_coh_bits,
    output logic                          tx_valid,
    output logic [$clog2(NUM_VC)-1:0]     tx_vc,
    output logic                          idle_req,
    output logic                          credit_overflow,
    output logic [1:0]                    state_o
);

    localparam int VC_W   = $clog2(NUM_VC);
    localparam int CNT_W  = $clog2(MAX_CREDITS + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(MAX_CREDITS);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_TIMEOUT);

    sched_state_e       state_q, state_d;
    logic [CNT_W-1:0]   credit_q [NUM_VC];
    logic [VC_W-1:0]    rr_ptr_q;
    logic [VC_W-1:0]    rr_ptr_next;
    logic [IDLE_W-1:0]  idle_cnt_q;

    logic [NUM_VC-1:0]  eligible;
    logic [NUM_VC-1:0]  grant;
    logic [VC_W-1:0]    grant_idx;
    logic               any_grant;
    logic [NUM_VC-1:0]  ret_hit;
    logic [NUM_VC-1:0]  at_max;
    logic               overflow_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DOWN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DOWN:    if (link_up) state_d = INIT;
            INIT:    state_d = link_up ? RUN : DOWN;
            RUN:     if (!link_up) state_d = DOWN;
            default: state_d = DOWN;
        endcase
    end

    // Credit returns only count in RUN; a return racing a grant on the same VC cancels out.
    always_comb begin
        eligible     = '0;
        ret_hit      = '0;
        at_max       = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            eligible[i] = req_valid[i] && (credit_q[i] != '0) && (state_q == RUN);
            ret_hit[i]  = credit_ret_valid && (credit_ret_vc == VC_W'(i)) && (state_q == RUN);
            at_max[i]   = (credit_q[i] == CREDIT_MAX);
        end
        overflow_hit = |(ret_hit & ~grant & at_max);
    end

    rr_arbiter #(
        .N (NUM_VC),
        .W (VC_W)
    ) u_arb (
        .eligible  (eligible),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready   = grant;
    assign rr_ptr_next = (grant_idx == VC_W'(NUM_VC - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++) credit_q[i] <= '0;
            credit_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (state_d == DOWN) begin
                    credit_q[i] <= '0;
                end else if (state_q == INIT) begin
                    credit_q[i] <= CREDIT_MAX;
                end else if (state_q == RUN) begin
                    if (ret_hit[i] && !grant[i]) begin
                        if (!at_max[i]) credit_q[i] <= credit_q[i] + 1'b1;
                    end else if (grant[i] && !ret_hit[i]) begin
                        credit_q[i] <= credit_q[i] - 1'b1;
                    end
                end
            end
            if (overflow_hit) credit_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            tx_valid    <= 1'b0;
            tx_payload  <= '0;
            tx_coh_bits <= '0;
            tx_vc       <= '0;
        end else begin
            tx_valid <= any_grant;
            if (any_grant) begin
                rr_ptr_q    <= rr_ptr_next;
                tx_payload  <= req_payload[grant_idx*PAYLOAD_W +: PAYLOAD_W];
                tx_coh_bits <= req_coh[grant_idx*COH_W +: COH_W];
                tx_vc       <= grant_idx;
            end
        end
    end

    // Idle counter only runs while the link stays in RUN; any request or link change clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else if (state_q != RUN || state_d != RUN || (|req_valid)) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    assign idle_req = (idle_cnt_q == IDLE_MAX);
    assign state_o  = state_q;

endmodule

// File: tb/tb_nvlink_tx_vc_scheduler.sv
// Directed scoreboard bench for the NVLink TX virtual-channel scheduler.
module tb_nvlink_tx_vc_scheduler;
    import nvlink_tx_pkg::*;

    localparam int NV = 4;
    localparam int PW = 96;
    localparam int CW = 8;

    logic              clk;
    logic              rst;
    logic              link_up;
    logic [NV-1:0]     req_valid;
    logic [NV-1:0]     req_ready;
    logic [NV*PW-1:0]  req_payload;
    logic [NV*CW-1:0]  req_coh;
    logic              credit_ret_valid;
    vc_idx_t           credit_ret_vc;
    logic [PW-1:0]     tx_payload;
    logic [CW-1:0]     tx_coh_bits;
    logic              tx_valid;
    vc_idx_t           tx_vc;
    logic              idle_req;
    logic              credit_overflow;
    logic [1:0]        state_o;

    typedef struct {
        vc_idx_t        vc;
        logic [PW-1:0]  payload;
        logic [CW-1:0]  coh;
    } flit_t;

    flit_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    tag    = 0;

    nvlink_tx_vc_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .link_up          (link_up),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_payload      (req_payload),
        .req_coh          (req_coh),
        .credit_ret_valid (credit_ret_valid),
        .credit_ret_vc    (credit_ret_vc),
        .tx_payload       (tx_payload),
        .tx_coh_bits      (tx_coh_bits),
        .tx_valid         (tx_valid),
        .tx_vc            (tx_vc),
        .idle_req         (idle_req),
        .credit_overflow  (credit_overflow),
        .state_o          (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] lanePayload(input int t, input int i);
        return {32'(t), 32'hC0DE0000 + 32'(i), 32'(t * 16 + i)};
    endfunction

    function automatic logic [CW-1:0] laneCoh(input int t, input int i);
        return {4'(t), 4'(i)};
    endfunction

    task automatic setLanes(input int t);
        tag = t;
        for (int i = 0; i < NV; i++) begin
            req_payload[i*PW +: PW] = lanePayload(t, i);
            req_coh[i*CW +: CW]     = laneCoh(t, i);
        end
    endtask

    task automatic pushExp(input int vc);
        flit_t f;
        f.vc      = vc_idx_t'(vc);
        f.payload = lanePayload(tag, vc);
        f.coh     = laneCoh(tag, vc);
        exp_q.push_back(f);
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive a new input vector just after the active edge, then settle at the following negedge.
    task automatic applyStimulus(input logic [NV-1:0] valid, input logic ret_v, input int ret_vc, input logic link);
        @(posedge clk);
        #1;
        req_valid        = valid;
        credit_ret_valid = ret_v;
        credit_ret_vc    = vc_idx_t'(ret_vc);
        link_up          = link;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && tx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_flit actual_vc=%0d expected=none", tx_vc);
            end else begin
                flit_t f;
                f = exp_q.pop_front();
                checkOutput("tx_vc", 128'(tx_vc), 128'(f.vc));
                checkOutput("tx_payload", 128'(tx_payload), 128'(f.payload));
                checkOutput("tx_coh_bits", 128'(tx_coh_bits), 128'(f.coh));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; link_up = 1'b0; req_valid = '0;
        credit_ret_valid = 1'b0; credit_ret_vc = '0;
        req_payload = '0; req_coh = '0;
        setLanes(1);

        // Reset and link bring-up
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_state", 128'(state_o), 128'(0));
        checkOutput("rst_tx_valid", 128'(tx_valid), 128'(0));
        checkOutput("rst_tx_payload", 128'(tx_payload), 128'(0));
        checkOutput("rst_tx_vc", 128'(tx_vc), 128'(0));
        checkOutput("rst_idle_req", 128'(idle_req), 128'(0));
        checkOutput("rst_overflow", 128'(credit_overflow), 128'(0));
        checkOutput("rst_req_ready", 128'(req_ready), 128'(0));
        applyStimulus(4'hF, 1'b0, 0, 1'b0);
        checkOutput("down_req_ready", 128'(req_ready), 128'(0));
        applyStimulus(4'h0, 1'b0, 0, 1'b1);
        checkOutput("down_state", 128'(state_o), 128'(0));
        applyStimulus(4'hF, 1'b0, 0, 1'b1);
        checkOutput("init_state", 128'(state_o), 128'(1));
        checkOutput("init_req_ready", 128'(req_ready), 128'(0));
        applyStimulus(4'h0, 1'b0, 0, 1'b1);
        checkOutput("run_state", 128'(state_o), 128'(2));

        // Overflow on a full VC0
        applyStimulus(4'h0, 1'b1, 0, 1'b1);
        checkOutput("ovf_before", 128'(credit_overflow), 128'(0));
        applyStimulus(4'h0, 1'b0, 0, 1'b1);
        checkOutput("ovf_set", 128'(credit_overflow), 128'(1));

        // Fairness: 8 credits per VC, strict rotation, then all stall
        for (int k = 0; k < 32; k++) begin
            applyStimulus(4'hF, 1'b0, 0, 1'b1);
            checkOutput($sformatf("rr_grant%0d", k), 128'(req_ready), 128'(4'b0001 << (k % 4)));
            pushExp(k % 4);
        end
        applyStimulus(4'hF, 1'b0, 0, 1'b1);
        checkOutput("rr_exhausted", 128'(req_ready), 128'(0));
        applyStimulus(4'h0, 1'b0, 0, 1'b1);

        // Refill VC2 with 8 returns, drain it, then one more credit
        setLanes(2);
        for (int k = 0; k < 8; k++) applyStimulus(4'h0, 1'b1, 2, 1'b1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0100, 1'b0, 0, 1'b1);
            checkOutput($sformatf("vc2_grant%0d", k), 128'(req_ready), 128'(4'b0100));
            pushExp(2);
        end
        applyStimulus(4'b0100, 1'b0, 0, 1'b1);
        checkOutput("vc2_stall", 128'(req_ready), 128'(0));
        applyStimulus(4'b0100, 1'b1, 2, 1'b1);
        checkOutput("vc2_ret_cycle", 128'(req_ready), 128'(0));
        applyStimulus(4'b0100, 1'b0, 0, 1'b1);
        checkOutput("vc2_regrant", 128'(req_ready), 128'(4'b0100));
        pushExp(2);
        applyStimulus(4'b0100, 1'b0, 0, 1'b1);
        checkOutput("vc2_stall2", 128'(req_ready), 128'(0));

        // VC1 with one credit: grant and return together keep the count at 1
        setLanes(3);
        applyStimulus(4'h0, 1'b1, 1, 1'b1);
        applyStimulus(4'b0010, 1'b1, 1, 1'b1);
        checkOutput("vc1_grant_ret", 128'(req_ready), 128'(4'b0010));
        pushExp(1);
        applyStimulus(4'b0010, 1'b0, 0, 1'b1);
        checkOutput("vc1_grant_again", 128'(req_ready), 128'(4'b0010));
        pushExp(1);
        applyStimulus(4'b0010, 1'b0, 0, 1'b1);
        checkOutput("vc1_stall", 128'(req_ready), 128'(0));

        // Idle timeout after 64 empty RUN cycles
        setLanes(4);
        applyStimulus(4'h0, 1'b0, 0, 1'b1);
        for (int j = 1; j <= 64; j++) begin
            applyStimulus(4'h0, 1'b0, 0, 1'b1);
            if (j == 63) checkOutput("idle_63", 128'(idle_req), 128'(0));
            if (j == 64) checkOutput("idle_64", 128'(idle_req), 128'(1));
        end
        applyStimulus(4'b1000, 1'b0, 0, 1'b1);
        checkOutput("idle_hold", 128'(idle_req), 128'(1));
        checkOutput("vc3_blocked", 128'(req_ready), 128'(0));
        applyStimulus(4'h0, 1'b0, 0, 1'b1);
        checkOutput("idle_clear", 128'(idle_req), 128'(0));
        checkOutput("ovf_sticky", 128'(credit_overflow), 128'(1));

        // Link drop while a flit is accepted
        applyStimulus(4'h0, 1'b1, 3, 1'b1);
        applyStimulus(4'b1000, 1'b0, 0, 1'b0);
        checkOutput("drop_grant", 128'(req_ready), 128'(4'b1000));
        pushExp(3);
        applyStimulus(4'b1000, 1'b0, 0, 1'b0);
        checkOutput("drop_state", 128'(state_o), 128'(0));
        checkOutput("drop_req_ready", 128'(req_ready), 128'(0));
        checkOutput("drop_idle", 128'(idle_req), 128'(0));
        applyStimulus(4'h0, 1'b1, 3, 1'b0);
        applyStimulus(4'h0, 1'b0, 0, 1'b1);
        applyStimulus(4'h0, 1'b0, 0, 1'b1);
        checkOutput("reup_init", 128'(state_o), 128'(1));
        applyStimulus(4'h0, 1'b0, 0, 1'b1);
        checkOutput("reup_run", 128'(state_o), 128'(2));
        checkOutput("ovf_still", 128'(credit_overflow), 128'(1));

        // Final reset clears the sticky flag
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("final_ovf", 128'(credit_overflow), 128'(0));
        checkOutput("final_state", 128'(state_o), 128'(0));
        checkOutput("final_tx_valid", 128'(tx_valid), 128'(0));
        repeat (2) @(negedge clk);
        checkOutput("sb_drain", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
